// File: rtl/key_pkg.sv
// Shared types and default timing for the four-key debounce front end.
// The defaults assume a 50 MHz system clock.
package key_pkg;

    localparam int NUM_KEYS = 4;

    localparam int DEF_DEBOUNCE_CYC = 1_000_000;   // 20 ms
    localparam int DEF_REPEAT_DLY   = 25_000_000;  // 500 ms
    localparam int DEF_REPEAT_PER   = 5_000_000;   // 100 ms
    localparam logic [NUM_KEYS-1:0] DEF_REPEAT_MASK = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } key_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_filter.sv
// One key: 2-FF synchroniser, debounce filter, press/auto-repeat FSM.
// The flag is registered, so it rises one cycle after the debounced level.
module key_filter
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int REPEAT_PER   = DEF_REPEAT_PER,
    parameter bit REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic flag,
    output logic held
);

    localparam int CW   = $clog2(DEBOUNCE_CYC);
    localparam int TMAX = max_int(REPEAT_DLY, REPEAT_PER);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] DLY_LOAD = TW'(REPEAT_DLY - 1);
    localparam logic [TW-1:0] PER_LOAD = TW'(REPEAT_PER - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          sample_pressed;
    logic          stable;
    logic [CW-1:0] cnt;

    key_state_t    state;
    key_state_t    state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          flag_nxt;

    // Stage p0/p1: bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign sample_pressed = ~sync_p1;

    // Debounce: any sample matching the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sample_pressed == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sample_pressed;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Release is tested before timer expiry so it always wins a tie.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        flag_nxt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (stable) begin
                    flag_nxt  = 1'b1;
                    timer_nxt = DLY_LOAD;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stable) begin
                    timer_nxt = '0;
                    state_nxt = ST_IDLE;
                end else if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else if (REPEAT_EN) begin
                    flag_nxt  = 1'b1;
                    timer_nxt = PER_LOAD;
                    state_nxt = ST_RPT;
                end
            end
            ST_RPT: begin
                if (!stable) begin
                    timer_nxt = '0;
                    state_nxt = ST_IDLE;
                end else if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else begin
                    flag_nxt  = 1'b1;
                    timer_nxt = PER_LOAD;
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            timer <= '0;
            flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            flag  <= flag_nxt;
        end
    end

    assign held = stable;

endmodule

// File: rtl/key_debounce4.sv
// Four independent debounced keys feeding lcd_fsm; keys selected by
// REPEAT_MASK also auto-repeat while held.
module key_debounce4
    import key_pkg::*;
#(
    parameter int                   DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int                   REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int                   REPEAT_PER   = DEF_REPEAT_PER,
    parameter logic [NUM_KEYS-1:0]  REPEAT_MASK  = DEF_REPEAT_MASK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic                key1_flag,
    output logic                key2_flag,
    output logic                key3_flag,
    output logic                key4_flag,
    output logic [NUM_KEYS-1:0] key_held
);

    logic [NUM_KEYS-1:0] flags;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_filter #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DLY   (REPEAT_DLY),
            .REPEAT_PER   (REPEAT_PER),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_filter (
            .clk     (clk),
            .rst     (rst),
            .key_raw (key_in[i]),
            .flag    (flags[i]),
            .held    (key_held[i])
        );
    end

    assign key1_flag = flags[0];
    assign key2_flag = flags[1];
    assign key3_flag = flags[2];
    assign key4_flag = flags[3];

endmodule

// File: tb/tb_key_debounce4.sv
// Self-checking bench for key_debounce4 with short timing parameters.
module tb_key_debounce4;

    localparam int         DB   = 4;
    localparam int         DLY  = 10;
    localparam int         PER  = 5;
    localparam logic [3:0] MASK = 4'b0110;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_in = 4'hF;
    logic       key1_flag, key2_flag, key3_flag, key4_flag;
    logic [3:0] key_held;
    logic [3:0] flags;

    int total = 0;
    int bad   = 0;

    // Reference model: raw-pin history, accepted level, and the number of
    // cycles the FSM has seen the key pressed (-1 while released).
    logic       hist [4][DB+1];
    logic [3:0] m_stable;
    logic [3:0] m_flag;
    int         run [4];

    assign flags = {key4_flag, key3_flag, key2_flag, key1_flag};

    key_debounce4 #(
        .DEBOUNCE_CYC (DB),
        .REPEAT_DLY   (DLY),
        .REPEAT_PER   (PER),
        .REPEAT_MASK  (MASK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key1_flag (key1_flag),
        .key2_flag (key2_flag),
        .key3_flag (key3_flag),
        .key4_flag (key4_flag),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // A level change is accepted once DB consecutive synchronised samples
    // (raw pin delayed by two edges) disagree with the accepted level.
    // Strobes: first pressed cycle, then DLY later, then every PER.
    function automatic void model_edge(input logic [3:0] raw, input logic r);
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                for (int j = 0; j <= DB; j++) hist[k][j] = 1'b1;
                m_stable[k] = 1'b0;
                m_flag[k]   = 1'b0;
                run[k]      = -1;
            end else begin
                bit all_diff;
                if (m_stable[k]) begin
                    run[k]++;
                    m_flag[k] = (run[k] == 0) ||
                                (MASK[k] && run[k] >= DLY && ((run[k] - DLY) % PER) == 0);
                end else begin
                    run[k]    = -1;
                    m_flag[k] = 1'b0;
                end
                all_diff = 1'b1;
                for (int j = 1; j <= DB; j++)
                    if ((!hist[k][j]) == m_stable[k]) all_diff = 1'b0;
                if (all_diff) m_stable[k] = ~m_stable[k];
                for (int j = DB; j >= 1; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = raw[k];
            end
        end
    endfunction

    task automatic tick(input logic [3:0] raw, input logic r);
        key_in = raw;
        rst    = r;
        @(posedge clk);
        model_edge(raw, r);
        #1;
    endtask

    task automatic test_reset();
        for (int t = 0; t < 3; t++) begin
            tick(4'hF, 1'b1);
            total++;
            if (flags !== 4'b0000 || key_held !== 4'b0000) begin
                bad++;
                $display("FAIL reset t=%0d flags=%b held=%b required 0000/0000", t, flags, key_held);
            end
        end
        for (int t = 0; t < 4; t++) begin
            tick(4'hF, 1'b0);
            total++;
            if (flags !== m_flag || key_held !== m_stable) begin
                bad++;
                $display("FAIL reset_idle t=%0d flags=%b/%b held=%b/%b", t, flags, m_flag, key_held, m_stable);
            end
        end
    endtask

    task automatic test_clean_press();
        int first = -1;
        int n = 0;
        for (int t = 0; t < 42; t++) begin
            tick((t < 30) ? 4'b1110 : 4'b1111, 1'b0);
            total++;
            if (flags !== m_flag || key_held !== m_stable) begin
                bad++;
                $display("FAIL clean_press t=%0d flags=%b/%b held=%b/%b", t, flags, m_flag, key_held, m_stable);
            end
            if (t >= 6 && t < 30) begin
                total++;
                if (key_held[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL clean_held t=%0d held0=%b required 1", t, key_held[0]);
                end
            end
            if (key1_flag === 1'b1) begin
                n++;
                if (first < 0) first = t;
            end
        end
        total++;
        if (first != 6) begin
            bad++;
            $display("FAIL clean_latency got=%0d required 6", first);
        end
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL clean_count got=%0d required 1", n);
        end
    endtask

    task automatic test_bounce();
        for (int t = 0; t < 30; t++) begin
            tick((t < 20 && ((t / 2) % 2) == 0) ? 4'b1101 : 4'b1111, 1'b0);
            total++;
            if (key2_flag !== 1'b0 || key_held[1] !== 1'b0) begin
                bad++;
                $display("FAIL bounce t=%0d flag2=%b held1=%b required 0/0", t, key2_flag, key_held[1]);
            end
            total++;
            if (flags !== m_flag || key_held !== m_stable) begin
                bad++;
                $display("FAIL bounce_model t=%0d flags=%b/%b held=%b/%b", t, flags, m_flag, key_held, m_stable);
            end
        end
    endtask

    task automatic test_auto_repeat();
        int times[$];
        int exp_off[6] = '{0, 10, 15, 20, 25, 30};
        for (int t = 0; t < 48; t++) begin
            tick((t < 34) ? 4'b1101 : 4'b1111, 1'b0);
            total++;
            if (flags !== m_flag || key_held !== m_stable) begin
                bad++;
                $display("FAIL repeat_model t=%0d flags=%b/%b held=%b/%b", t, flags, m_flag, key_held, m_stable);
            end
            if (key2_flag === 1'b1) times.push_back(t);
        end
        total++;
        if (times.size() != 6) begin
            bad++;
            $display("FAIL repeat_count got=%0d required 6", times.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (times[i] - times[0] != exp_off[i] || times[0] != 6) begin
                    bad++;
                    $display("FAIL repeat_time idx=%0d got=%0d required %0d", i, times[i] - 6, exp_off[i]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int f3 = -1, f4 = -1, n3 = 0, n4 = 0;
        for (int t = 0; t < 40; t++) begin
            tick((t < 25) ? 4'b0011 : 4'b1111, 1'b0);
            total++;
            if (flags !== m_flag || key_held !== m_stable) begin
                bad++;
                $display("FAIL simul_model t=%0d flags=%b/%b held=%b/%b", t, flags, m_flag, key_held, m_stable);
            end
            if (key3_flag === 1'b1) begin n3++; if (f3 < 0) f3 = t; end
            if (key4_flag === 1'b1) begin n4++; if (f4 < 0) f4 = t; end
        end
        total++;
        if (f3 != 6 || f4 != 6) begin
            bad++;
            $display("FAIL simul_first got=%0d/%0d required 6/6", f3, f4);
        end
        total++;
        if (n3 != 4 || n4 != 1) begin
            bad++;
            $display("FAIL simul_count got=%0d/%0d required 4/1", n3, n4);
        end
    endtask

    task automatic test_reset_mid_hold();
        int first = -1;
        for (int t = 0; t < 52; t++) begin
            tick((t < 40) ? 4'b1101 : 4'b1111, (t == 18));
            if (t == 18) begin
                total++;
                if (flags !== 4'b0000 || key_held !== 4'b0000) begin
                    bad++;
                    $display("FAIL midreset_clear flags=%b held=%b required 0000/0000", flags, key_held);
                end
            end
            total++;
            if (flags !== m_flag || key_held !== m_stable) begin
                bad++;
                $display("FAIL midreset_model t=%0d flags=%b/%b held=%b/%b", t, flags, m_flag, key_held, m_stable);
            end
            if (t > 18 && first < 0 && key2_flag === 1'b1) first = t;
        end
        total++;
        if (first - 19 != 6) begin
            bad++;
            $display("FAIL midreset_latency got=%0d required 6", first - 19);
        end
    endtask

    task automatic test_collision();
        int n3 = 0, first = -1;
        for (int t = 0; t < 30; t++) begin
            tick((t < 15) ? 4'b1011 : 4'b1111, 1'b0);
            total++;
            if (flags !== m_flag || key_held !== m_stable) begin
                bad++;
                $display("FAIL collide_model t=%0d flags=%b/%b held=%b/%b", t, flags, m_flag, key_held, m_stable);
            end
            if (key3_flag === 1'b1) n3++;
            if (t == 20) begin
                total++;
                if (key_held[2] !== 1'b0) begin
                    bad++;
                    $display("FAIL collide_held got=%b required 0", key_held[2]);
                end
            end
            if (t == 21) begin
                total++;
                if (key3_flag !== 1'b0) begin
                    bad++;
                    $display("FAIL collide_strobe got=%b required 0", key3_flag);
                end
            end
        end
        total++;
        if (n3 != 2) begin
            bad++;
            $display("FAIL collide_count got=%0d required 2", n3);
        end
        for (int t = 0; t < 24; t++) begin
            tick((t < 10) ? 4'b1011 : 4'b1111, 1'b0);
            total++;
            if (flags !== m_flag || key_held !== m_stable) begin
                bad++;
                $display("FAIL collide_again t=%0d flags=%b/%b held=%b/%b", t, flags, m_flag, key_held, m_stable);
            end
            if (first < 0 && key3_flag === 1'b1) first = t;
        end
        total++;
        if (first != 6) begin
            bad++;
            $display("FAIL collide_repress got=%0d required 6", first);
        end
    endtask

    task automatic test_random();
        logic [3:0] lvl = 4'hF;
        int rem [4] = '{0, 0, 0, 0};
        for (int t = 0; t < 1500; t++) begin
            for (int k = 0; k < 4; k++) begin
                if (rem[k] == 0) begin
                    lvl[k] = $urandom_range(0, 1);
                    rem[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
                end
                rem[k]--;
            end
            tick(lvl, ($urandom_range(0, 299) == 0));
            total++;
            if (flags !== m_flag || key_held !== m_stable) begin
                bad++;
                $display("FAIL random t=%0d key_in=%b flags=%b/%b held=%b/%b",
                         t, lvl, flags, m_flag, key_held, m_stable);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        test_collision();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
